// File: rtl/price_pkg.sv
`default_nettype none
// ============================================================================
// Module      : price_pkg
// Description : Shared types and arithmetic helpers for the price accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package price_pkg;

  // Transaction state: nothing accepted yet, accumulating, final total held.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Operand width of the helpers; callers zero-extend into it and cast back.
  localparam int unsigned c_OP_W = 64;

  // Unsigned add clamped to (2^width - 1). Valid for width < c_OP_W.
  function automatic logic [c_OP_W-1:0] sat_add(
    input logic [c_OP_W-1:0] a,
    input logic [c_OP_W-1:0] b,
    input int unsigned       width
  );
    logic [c_OP_W:0]   sum;
    logic [c_OP_W-1:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (64'd1 << width) - 64'd1;
    if (sum > {1'b0, max_val}) begin
      sat_add = max_val;
    end else begin
      sat_add = sum[c_OP_W-1:0];
    end
  endfunction

  // True when the unclamped sum would exceed (2^width - 1).
  function automatic logic add_ovf(
    input logic [c_OP_W-1:0] a,
    input logic [c_OP_W-1:0] b,
    input int unsigned       width
  );
    logic [c_OP_W:0]   sum;
    logic [c_OP_W-1:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (64'd1 << width) - 64'd1;
    add_ovf = (sum > {1'b0, max_val});
  endfunction

endpackage
`default_nettype wire

// File: rtl/price_mult_stage.sv
`default_nettype none
// ============================================================================
// Module      : price_mult_stage
// Description : Two registered stages: operand capture, then full-width
//               unsigned price x quantity product. Flush drops both stages.
// Revision    : 1.0 - initial release
// ============================================================================
module price_mult_stage
  import price_pkg::*;
#(
  parameter int unsigned PRICE_W = 4,
  parameter int unsigned NUM_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [PRICE_W-1:0]         price_i,
  input  logic [NUM_W-1:0]           num_i,
  output logic                       s1_valid_o,
  output logic                       valid_o,
  output logic [PRICE_W+NUM_W-1:0]   product_o
);

  localparam int unsigned c_PROD_W = PRICE_W + NUM_W;

  logic [PRICE_W-1:0]  price_q, price_d;
  logic [NUM_W-1:0]    num_q,   num_d;
  logic                s1_valid_q, s1_valid_d;
  logic [c_PROD_W-1:0] prod_q,  prod_d;
  logic                s2_valid_q, s2_valid_d;

  // Next-state: capture operands on accept, multiply whatever stage 1 holds.
  // The product register holds its last value so item_total stays visible.
  always_comb begin
    price_d    = price_q;
    num_d      = num_q;
    s1_valid_d = 1'b0;
    prod_d     = prod_q;
    s2_valid_d = 1'b0;
    if (flush_i) begin
      price_d = '0;
      num_d   = '0;
      prod_d  = '0;
    end else begin
      if (valid_i) begin
        price_d    = price_i;
        num_d      = num_i;
        s1_valid_d = 1'b1;
      end
      if (s1_valid_q) begin
        prod_d     = c_PROD_W'(price_q) * c_PROD_W'(num_q);
        s2_valid_d = 1'b1;
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      price_q    <= '0;
      num_q      <= '0;
      s1_valid_q <= 1'b0;
      prod_q     <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      price_q    <= price_d;
      num_q      <= num_d;
      s1_valid_q <= s1_valid_d;
      prod_q     <= prod_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign s1_valid_o = s1_valid_q;
  assign valid_o    = s2_valid_q;
  assign product_o  = prod_q;

endmodule
`default_nettype wire

// File: rtl/price_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : price_accumulator
// Description : Pipelined price x quantity totaliser with saturating running
//               total, item counter and checkout/drain state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module price_accumulator
  import price_pkg::*;
#(
  parameter int unsigned PRICE_W   = 4,
  parameter int unsigned NUM_W     = 4,
  parameter int unsigned TOTAL_W   = 12,
  parameter int unsigned MAX_ITEMS = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             in_valid,
  input  logic [PRICE_W-1:0]               price,
  input  logic [NUM_W-1:0]                 num,
  output logic                             in_ready,
  input  logic                             checkout,
  output logic [PRICE_W+NUM_W-1:0]         item_total,
  output logic [TOTAL_W-1:0]               total,
  output logic [$clog2(MAX_ITEMS+1)-1:0]   item_cnt,
  output logic                             overflow,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned       c_CNT_W   = $clog2(MAX_ITEMS + 1);
  localparam int unsigned       c_PROD_W  = PRICE_W + NUM_W;
  localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_ITEMS);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  state_t               state_q,   state_d;
  logic [TOTAL_W-1:0]   total_q,   total_d;
  logic [c_CNT_W-1:0]   cnt_q,     cnt_d;
  logic                 ovf_q,     ovf_d;
  logic                 ck_pend_q, ck_pend_d;
  logic                 done_q,    done_d;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_s1_valid;
  logic                 w_s2_valid;
  logic [c_PROD_W-1:0]  w_item_total;
  logic [TOTAL_W-1:0]   w_sat_sum;
  logic                 w_sum_ovf;

  // Ready depends on registers only so the front end sees no comb path.
  assign w_in_ready = (state_q != S_DONE) && !ck_pend_q && (cnt_q < c_MAX_CNT);
  assign w_accept   = in_valid && w_in_ready && !clr;

  price_mult_stage #(
    .PRICE_W (PRICE_W),
    .NUM_W   (NUM_W)
  ) u_mult (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (clr),
    .valid_i    (w_accept),
    .price_i    (price),
    .num_i      (num),
    .s1_valid_o (w_s1_valid),
    .valid_o    (w_s2_valid),
    .product_o  (w_item_total)
  );

  assign w_sat_sum = TOTAL_W'(sat_add(64'(total_q), 64'(w_item_total), TOTAL_W));
  assign w_sum_ovf = add_ovf(64'(total_q), 64'(w_item_total), TOTAL_W);

  // Next-state: clear wins over everything; checkout completes once drained.
  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    ck_pend_d = ck_pend_q;
    done_d    = 1'b0;
    if (clr) begin
      state_d   = S_IDLE;
      total_d   = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      ck_pend_d = 1'b0;
    end else begin
      if (w_accept) begin
        cnt_d = cnt_q + c_CNT_ONE;
        if (state_q == S_IDLE) begin
          state_d = S_ACC;
        end
      end
      if (w_s2_valid) begin
        total_d = w_sat_sum;
        if (w_sum_ovf) begin
          ovf_d = 1'b1;
        end
      end
      if (checkout && (state_q != S_DONE)) begin
        ck_pend_d = 1'b1;
      end
      if (ck_pend_q && !w_s1_valid && !w_s2_valid) begin
        state_d   = S_DONE;
        done_d    = 1'b1;
        ck_pend_d = 1'b0;
      end
    end
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      total_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ck_pend_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ck_pend_q <= ck_pend_d;
      done_q    <= done_d;
    end
  end

  assign in_ready   = w_in_ready;
  assign item_total = w_item_total;
  assign total      = total_q;
  assign item_cnt   = cnt_q;
  assign overflow   = ovf_q;
  assign busy       = w_s1_valid | w_s2_valid | ck_pend_q;
  assign done       = done_q;

endmodule
`default_nettype wire
